// File: rtl/vga_scan_gen.sv
// VGA scan timing generator: pixel-rate divider, h/v counters, registered
// active-low syncs and blanked colour, plus a once-per-frame pulse.
module vga_scan_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] color,
    output logic [9:0] colPos,
    output logic [9:0] rowPos,
    output logic       visible,
    output logic       pix_tick,
    output logic       frame_tick,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] H_SYNC_ON  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_OFF = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_ON  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_OFF = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Forcing 0 outside the visible window also keeps an undriven colour off the DAC.
    function automatic logic [5:0] blank_color(input logic vis, input logic [5:0] c);
        return vis ? c : 6'd0;
    endfunction

    logic [DIV_W-1:0] div_p0;
    logic [9:0]       h_cnt_p0;
    logic [9:0]       v_cnt_p0;
    logic             vld_p0;
    logic             vis_p0;
    logic [5:0]       rgb_p1;
    logic             hsync_p1;
    logic             vsync_p1;

    assign vld_p0 = (div_p0 == DIV_LAST);
    assign vis_p0 = (h_cnt_p0 < H_VIS_END) && (v_cnt_p0 < V_VIS_END);

    // Stage p0: pixel divider and scan position counters
    always_ff @(posedge clk) begin
        if (reset) begin
            div_p0   <= '0;
            h_cnt_p0 <= '0;
            v_cnt_p0 <= '0;
        end else if (vld_p0) begin
            div_p0 <= '0;
            if (h_cnt_p0 == H_LAST) begin
                h_cnt_p0 <= '0;
                v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? 10'd0 : v_cnt_p0 + 10'd1;
            end else begin
                h_cnt_p0 <= h_cnt_p0 + 10'd1;
            end
        end else begin
            div_p0 <= div_p0 + 1'b1;
        end
    end

    // Stage p1: one pixel behind the counters, syncs and colour stay aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_p1   <= '0;
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
        end else if (vld_p0) begin
            rgb_p1   <= blank_color(vis_p0, color);
            hsync_p1 <= !((h_cnt_p0 >= H_SYNC_ON) && (h_cnt_p0 < H_SYNC_OFF));
            vsync_p1 <= !((v_cnt_p0 >= V_SYNC_ON) && (v_cnt_p0 < V_SYNC_OFF));
        end
    end

    assign colPos     = h_cnt_p0;
    assign rowPos     = v_cnt_p0;
    assign visible    = vis_p0;
    assign pix_tick   = vld_p0;
    assign frame_tick = vld_p0 && (h_cnt_p0 == H_VIS_LAST) && (v_cnt_p0 == V_VIS_LAST);
    assign hsync      = hsync_p1;
    assign vsync      = vsync_p1;
    assign rgb        = rgb_p1;

endmodule
